// File: rtl/button_tick_gen.sv
//==============================================================================
// Module   : button_tick_gen
// Brief    : Two-flop synchronizer, per-button debounce, press-edge pulses and
//            a tick_cycle prescaler for the downstream counter logic.
//            Optional feature macro: BTN_AUTOREPEAT_EN (press-driven ticks).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_tick_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_PERIOD     = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] press_pulse,
    output logic       tick_cycle
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(TICK_PERIOD);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_PERIOD - 1);

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    db;
    logic [3:0]    db_nxt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic          tick_nxt;
    logic          wrap;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        logic [DW-1:0] cnt;

        assign db_nxt[i] = ((s2[i] != db[i]) && (cnt == DB_LAST)) ? s2[i] : db[i];

        // Any sample that agrees with the current level discards accumulated credit.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if ((s2[i] == db[i]) || (cnt == DB_LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign wrap = (pcnt == TICK_LAST);

`ifdef BTN_AUTOREPEAT_EN
    logic press_any;
    logic held_any;

    assign press_any = |(db_nxt & ~db);
    assign held_any  = |db;

    // A press restarts the period; a press right after a tick is absorbed so
    // the strobe is never two cycles wide.
    always_comb begin
        tick_nxt = 1'b0;
        pcnt_nxt = '0;
        if (press_any) begin
            tick_nxt = ~tick_cycle;
            pcnt_nxt = '0;
        end else if (held_any) begin
            tick_nxt = wrap;
            pcnt_nxt = wrap ? '0 : pcnt + 1'b1;
        end
    end
`else
    always_comb begin
        tick_nxt = wrap;
        pcnt_nxt = wrap ? '0 : pcnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= '0;
            s2          <= '0;
            db          <= '0;
            press_pulse <= '0;
            pcnt        <= '0;
            tick_cycle  <= 1'b0;
        end else begin
            s1          <= btn_raw;
            s2          <= s1;
            db          <= db_nxt;
            press_pulse <= db_nxt & ~db;
            pcnt        <= pcnt_nxt;
            tick_cycle  <= tick_nxt;
        end
    end

    assign up    = db[0];
    assign down  = db[1];
    assign left  = db[2];
    assign right = db[3];

endmodule

`default_nettype wire

// File: tb/tb_button_tick_gen.sv
//==============================================================================
// Module   : tb_button_tick_gen
// Brief    : Directed, table-driven bench for button_tick_gen (DEBOUNCE=4, TICK=8).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_button_tick_gen;

    localparam int DB = 4;
    localparam int TP = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       up, down, left, right, tick_cycle;
    logic [3:0] press_pulse;
    logic [3:0] lvl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign lvl = {right, left, down, up};

    button_tick_gen #(
        .DEBOUNCE_CYCLES (DB),
        .TICK_PERIOD     (TP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .up          (up),
        .down        (down),
        .left        (left),
        .right       (right),
        .press_pulse (press_pulse),
        .tick_cycle  (tick_cycle)
    );

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic [3:0] lvl;
        logic [3:0] press;
        logic       tick;
    } vec_t;

    vec_t tv[11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int clk_no,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @clock %0d: got %0h expected %0h", name, clk_no, act, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) step();
        rst     = 1'b0;
    endtask

    initial begin
        // Reset with all buttons pressed, then release: levels rise at clock 6.
        tv[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[2]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[3]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[4]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[5]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[6]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[7]  = '{1'b0, 4'hF, 4'h0, 4'h0, 1'b0};
        tv[8]  = '{1'b0, 4'hF, 4'hF, 4'hF, AR};
        tv[9]  = '{1'b0, 4'hF, 4'hF, 4'h0, 1'b0};
        tv[10] = '{1'b0, 4'hF, 4'hF, 4'h0, !AR};

        for (int i = 0; i < 11; i++) begin
            rst     = tv[i].rst;
            btn_raw = tv[i].btn;
            step();
            check("rst_levels", i - 2, 32'(lvl), 32'(tv[i].lvl));
            check("rst_press",  i - 2, 32'(press_pulse), 32'(tv[i].press));
            check("rst_tick",   i - 2, 32'(tick_cycle), 32'(tv[i].tick));
        end

        // 3-clock glitch on left must be rejected.
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            btn_raw = (c <= 3) ? 4'b0100 : 4'b0000;
            step();
            check("glitch_left",  c, 32'(left), 32'(0));
            check("glitch_press", c, 32'(press_pulse), 32'(0));
        end

        // 4-clock hold on left is just enough to be accepted.
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            btn_raw = (c <= 4) ? 4'b0100 : 4'b0000;
            step();
            check("hold4_left",  c, 32'(left), 32'((c >= 6) && (c <= 9)));
            check("hold4_press", c, 32'(press_pulse), (c == 6) ? 32'h4 : 32'h0);
        end

        // Idle buttons: free-running ticks, or none at all in autorepeat mode.
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            step();
            check("idle_tick", c, 32'(tick_cycle), 32'(!AR && (c % TP == 0)));
        end

        // Up held 21..50; down pressed so its edge lands on pcnt == 7 (clock 34).
        do_reset();
        for (int c = 1; c <= 70; c++) begin
            btn_raw = {2'b00, (c >= 29) && (c <= 50), (c >= 21) && (c <= 50)};
            step();
            check("ar_up",    c, 32'(up),   32'((c >= 26) && (c <= 55)));
            check("ar_down",  c, 32'(down), 32'((c >= 34) && (c <= 55)));
            check("ar_press", c, 32'(press_pulse),
                  (c == 26) ? 32'h1 : ((c == 34) ? 32'h2 : 32'h0));
            check("ar_tick",  c, 32'(tick_cycle),
                  AR ? 32'((c == 26) || (c == 34) || (c == 42) || (c == 50))
                     : 32'(c % TP == 0));
        end

        // Reset two counts into debouncing discards all progress.
        do_reset();
        btn_raw = 4'b0010;
        repeat (4) step();
        check("mid_down_pre", 4, 32'(down), 32'(0));
        rst = 1'b1;
        step();
        check("mid_rst_levels", 0, 32'(lvl), 32'(0));
        check("mid_rst_press",  0, 32'(press_pulse), 32'(0));
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            step();
            check("mid_down",  c, 32'(down), 32'(c >= 6));
            check("mid_press", c, 32'(press_pulse), (c == 6) ? 32'h2 : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
